// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: dual-port word memory with an edge-qualified write port and a
// dwell-timed read-address scanner (run up/down, hold, manual step).
module ram_scan_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5,
  parameter int DWELL  = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              tick,
  output logic              wr_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW = $clog2(DWELL) + 1;
  typedef enum logic [1:0] {RUN_UP = 2'b00, HOLD = 2'b01, STEP = 2'b10, RUN_DOWN = 2'b11} mode_t;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_wr_q, r_step_q, w_wr_edge, w_step_edge, w_run, w_wrap, w_adv;
  logic [ADDR_W-1:0] w_addr_nxt;
  mode_t             w_mode;
  always_comb begin
    w_mode      = mode_t'(mode);
    w_wr_edge   = wr_req & ~r_wr_q;
    w_step_edge = step & ~r_step_q;
    w_run       = (w_mode == RUN_UP) || (w_mode == RUN_DOWN);
    w_wrap      = r_cnt == CW'(DWELL - 1);
    w_adv       = w_run ? w_wrap : (w_mode == STEP) && w_step_edge;
    w_cnt_nxt   = w_run ? (w_wrap ? '0 : r_cnt + 1'b1) : (w_mode == STEP ? '0 : r_cnt);
    w_addr_nxt  = (w_mode == RUN_DOWN) ? rd_addr - 1'b1 : rd_addr + 1'b1;
  end
  // memory contents survive reset; only the write itself is blocked
  always_ff @(posedge clk)
    if (!reset && w_wr_edge) r_mem[wr_addr] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_q   <= wr_req;
      r_step_q <= step;
      r_cnt    <= '0;
      rd_addr  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      tick     <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      r_wr_q   <= wr_req;
      r_step_q <= step;
      r_cnt    <= w_cnt_nxt;
      if (w_adv) rd_addr <= w_addr_nxt;
      rd_data  <= (w_wr_edge && wr_addr == rd_addr) ? wr_data : r_mem[rd_addr];
      rd_valid <= 1'b1;
      tick     <= w_adv;
      wr_done  <= w_wr_edge;
    end
  end
endmodule
